// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the multi-cycle data-memory responder.
package mem_responder_pkg;

  localparam int DATA_W      = 16;
  localparam int LATENCY_MIN = 1;
  localparam int LATENCY_MAX = 15;
  localparam int CNT_W       = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Request attributes latched at accept; the word index is kept separately
  // because its width depends on DEPTH.
  typedef struct packed {
    logic              wr;
    logic              una;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/mem_responder_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one combinational read
// port, whole array cleared by the asynchronous active-low reset.
module mem_responder_array
  import mem_responder_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     widx,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     ridx,
  output logic [DATA_W-1:0] rdata
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;

  // Write port; reset wipes every word so post-reset reads return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) mem <= '0;
    else if (we) mem[widx] <= wdata;
  end

  assign rdata = mem[ridx];

endmodule

// File: rtl/mem_responder.sv
// Multi-cycle memory responder for the processor memory stage.
// Accepts one request, holds stall while busy, pulses done after LATENCY
// cycles. Optional last-index fast read path: MEM_RESPONDER_LASTHIT_EN.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              wr,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] data_in,
  output logic [DATA_W-1:0] data_out,
  output logic              done,
  output logic              stall,
  output logic              hit,
  output logic              err
);

  localparam int AW = $clog2(DEPTH);

  if (LATENCY < LATENCY_MIN || LATENCY > LATENCY_MAX) begin : g_bad_latency
    $error("mem_responder: LATENCY out of range 1..15");
  end
  if ((1 << AW) != DEPTH) begin : g_bad_depth
    $error("mem_responder: DEPTH must be a power of 2");
  end

  state_e            state, state_nxt;
  logic [CNT_W-1:0]  cnt, cnt_nxt;
  req_t              cap, in_req, cur;
  logic [AW-1:0]     cap_idx, in_idx, cur_idx;
  logic              accept, fast, enter_done, we;
  logic [DATA_W-1:0] rd_data;

  // Bits above the word index are deliberately ignored (index wraps).
  logic unused_addr;
  assign unused_addr = ^(addr >> (AW + 1));

  assign in_idx = addr[AW:1];
  assign in_req = '{wr: wr, una: addr[0], data: data_in};
  assign accept = en & (state != BUSY);
  assign stall  = (state == BUSY) | (en & (state != BUSY));
  assign done   = (state == DONE);

  // When a request goes straight to DONE its attributes come from the inputs,
  // otherwise from the capture registers.
  assign cur        = accept ? in_req : cap;
  assign cur_idx    = accept ? in_idx : cap_idx;
  assign enter_done = (state_nxt == DONE);
  assign we         = enter_done & cur.wr & ~cur.una;

`ifdef MEM_RESPONDER_LASTHIT_EN
  logic [AW-1:0] last_idx;
  logic          last_vld;

  assign fast = accept & ~wr & ~addr[0] & last_vld & (in_idx == last_idx);

  // Remember the most recent aligned completion; hit flags a fast completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_idx <= '0;
      last_vld <= 1'b0;
      hit      <= 1'b0;
    end else begin
      hit <= fast;
      if (enter_done & ~cur.una) begin
        last_idx <= cur_idx;
        last_vld <= 1'b1;
      end
    end
  end
`else
  assign fast = 1'b0;
  assign hit  = 1'b0;
`endif

  // Next-state and countdown: accept from IDLE/DONE, count down in BUSY.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE, DONE: begin
        if (accept) begin
          cnt_nxt   = CNT_W'(LATENCY - 1);
          state_nxt = ((LATENCY == 1) || fast) ? DONE : BUSY;
        end else begin
          state_nxt = IDLE;
        end
      end
      BUSY: begin
        cnt_nxt = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, counter and request capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cap     <= '0;
      cap_idx <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        cap     <= in_req;
        cap_idx <= in_idx;
      end
    end
  end

  // Read data and error pulse, both registered on the edge entering DONE;
  // err also fires the cycle after any en seen while BUSY.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out <= '0;
      err      <= 1'b0;
    end else begin
      err <= (en & (state == BUSY)) | (enter_done & cur.una);
      if (enter_done & (~cur.wr | cur.una))
        data_out <= cur.una ? '0 : rd_data;
    end
  end

  mem_responder_array #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_array (
    .clk  (clk),
    .rst  (rst),
    .we   (we),
    .widx (cur_idx),
    .wdata(cur.data),
    .ridx (cur_idx),
    .rdata(rd_data)
  );

endmodule

// File: tb/tb_mem_responder.sv
// Randomized self-checking bench for mem_responder against a transaction-level
// model (word array + last-index tracker).
module tb_mem_responder;

  localparam int LAT   = 4;
  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en = 1'b0, wr = 1'b0;
  logic [15:0] addr = '0, data_in = '0;
  logic [15:0] data_out;
  logic        done, stall, hit, err;

  mem_responder #(.LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .en(en), .wr(wr), .addr(addr), .data_in(data_in),
    .data_out(data_out), .done(done), .stall(stall), .hit(hit), .err(err)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_pass = 0;
  logic [15:0] mem_m [DEPTH];
  logic [15:0] exp_dout;
  int          last_idx_m;
  bit          last_vld_m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic model_reset();
    foreach (mem_m[i]) mem_m[i] = '0;
    exp_dout   = '0;
    last_idx_m = 0;
    last_vld_m = 1'b0;
  endtask

  // Present a request at the current negedge (DUT idle or in its done cycle),
  // wait for done and check latency, stall, err, hit and read data.
  task automatic txn(input bit w, input logic [15:0] a, input logic [15:0] d);
    int idx, n, lat;
    bit una, fast, stall_bad;
    idx  = (int'(a) >> 1) % DEPTH;
    una  = a[0];
    fast = 1'b0;
`ifdef MEM_RESPONDER_LASTHIT_EN
    fast = !w && !una && last_vld_m && (idx == last_idx_m);
`endif
    lat = fast ? 1 : LAT;
    en = 1'b1; wr = w; addr = a; data_in = d;
    #1;
    chk("stall_accept", stall, 1);
    @(posedge clk); #1;
    en = 1'b0; wr = 1'($urandom); addr = 16'($urandom); data_in = 16'($urandom);
    n = 0; stall_bad = 1'b0;
    do begin
      @(negedge clk);
      n++;
      if (!done && !stall) stall_bad = 1'b1;
    end while (!done && n < 40);
    if (!una) begin
      if (w) mem_m[idx] = d;
      else   exp_dout = mem_m[idx];
      last_idx_m = idx;
      last_vld_m = 1'b1;
    end else begin
      exp_dout = '0;
    end
    chk("latency", n, lat);
    chk("busy_stall_gap", stall_bad, 0);
    chk("done_stall", stall, 0);
    chk("done_err", err, una);
    chk("done_hit", hit, fast);
    if (!w || una) chk("rdata", data_out, exp_dout);
  endtask

  // One quiet cycle: no done, no err, no stall, data_out held.
  task automatic idle();
    @(negedge clk);
    chk("idle_done", done, 0);
    chk("idle_err", err, 0);
    chk("idle_stall", stall, 0);
    chk("idle_hold", data_out, exp_dout);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_hit", hit, 0);
    chk("rst_dout", data_out, 0);
    chk("rst_stall", stall, 0);
    rst = 1'b1;
    @(negedge clk);

    // basic write then read
    txn(1'b1, 16'h0010, 16'hBEEF); idle();
    txn(1'b0, 16'h0010, 16'h0000); idle();

    // back-to-back write then read of the same word
    txn(1'b1, 16'h0020, 16'h1234);
    txn(1'b0, 16'h0020, 16'h0000); idle();

    // unaligned read, unaligned write, then aligned readback
    txn(1'b0, 16'h0011, 16'h0000); idle();
    txn(1'b1, 16'h0011, 16'h5555); idle();
    txn(1'b0, 16'h0010, 16'h0000); idle();

    // en while BUSY: err next cycle, original write completes on time
    en = 1'b1; wr = 1'b1; addr = 16'h0040; data_in = 16'h4242;
    @(posedge clk); #1; en = 1'b0;
    @(negedge clk);
    en = 1'b1; wr = 1'b0; addr = 16'h0050;
    #1; chk("busy_en_stall", stall, 1);
    @(negedge clk);
    chk("busy_en_err", err, 1);
    en = 1'b0;
    @(negedge clk);
    chk("busy_en_err_once", err, 0);
    chk("busy_en_no_early_done", done, 0);
    @(negedge clk);
    chk("busy_en_done", done, 1);
    chk("busy_en_done_err", err, 0);
    mem_m[32] = 16'h4242; last_idx_m = 32; last_vld_m = 1'b1;
    idle();
    txn(1'b0, 16'h0040, 16'h0000); idle();

    // index wrap
    txn(1'b1, 16'h0200, 16'h7777); idle();
    txn(1'b0, 16'h0000, 16'h0000); idle();

    // randomized traffic over a small index set with aliased upper bits
    for (int i = 0; i < 80; i++) begin
      bit          w;
      logic [15:0] a;
      w = 1'($urandom_range(0, 1));
      a = 16'(($urandom_range(0, 3) << 9) | ($urandom_range(0, 7) << 1) |
              ($urandom_range(0, 7) == 0 ? 1 : 0));
      txn(w, a, 16'($urandom));
      if ($urandom_range(0, 1) == 1) idle();
    end
    idle();

    // reset in the middle of a write
    en = 1'b1; wr = 1'b1; addr = 16'h0030; data_in = 16'hAAAA;
    @(posedge clk); #1; en = 1'b0;
    @(posedge clk);
    @(posedge clk); #2;
    rst = 1'b0;
    #1;
    chk("mid_rst_done", done, 0);
    chk("mid_rst_err", err, 0);
    chk("mid_rst_hit", hit, 0);
    chk("mid_rst_dout", data_out, 0);
    chk("mid_rst_stall", stall, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    txn(1'b0, 16'h0030, 16'h0000); idle();
    txn(1'b0, 16'h0010, 16'h0000); idle();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle data-memory responder that services the processor memory stage (en/wr/addr/data_in) over a stall/done handshake.
- The processor is the requester. This block is the responder: it accepts one request, holds stall while busy, then returns read data or commits the write with a done pulse.
- Replaces the single-cycle memory for stall/freeze testing of the pipeline.

Parameters:
- LATENCY, 4, cycles from accept to done; legal range 1..15.
- DEPTH, 256, number of 16-bit words; power of 2.
- AW, clog2(DEPTH), word-address width; derived, not overridable.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; asynchronous, active-low.
- en  input  1  request valid; accepted when state != BUSY.
- wr  input  1  1 = write, 0 = read; sampled at accept.
- addr  input  16  byte address; word index = addr[AW:1]; bit 0 must be 0.
- data_in  input  16  write data; sampled at accept.
- data_out  output  16  read data; registered, valid while done = 1, held until the next done.
- done  output  1  one-cycle completion pulse.
- stall  output  1  requester must freeze; combinational.
- hit  output  1  fast-path completion; pulses with done (see Optional Feature).
- err  output  1  one-cycle protocol/alignment error pulse.

Behaviour:
- Reset (rst = 0, async): state = IDLE; count = 0; data_out, done, hit, err = 0; array cleared to 0. An in-flight write is dropped.
- States:
  - IDLE, BUSY, DONE.
  - Accept occurs in IDLE or DONE when en = 1: capture wr/addr/data_in; count = LATENCY-1; next state = BUSY, or DONE if LATENCY = 1.
  - BUSY: count decrements each cycle; when count == 1, next state = DONE.
  - DONE: done = 1 for exactly this cycle. With en = 1, accept a new request (back-to-back, no bubble). Otherwise go to IDLE.
- Latency: request accepted at edge T; done high in cycle T+LATENCY.
- stall = (state == BUSY) | (en & state != BUSY). It is high from the accept cycle through the cycle before done, and low in the done cycle unless a new request is presented.
- Write commit: the array word is written on the edge entering DONE. data_out keeps its previous value on writes.
- Read: data_out is loaded on the edge entering DONE from the array word at the captured index.
- Address: the index uses addr[AW:1]; upper bits are ignored, so the index wraps modulo DEPTH.
- Unaligned (addr[0] = 1 at accept):
  - Full latency still applies; err pulses with done.
  - No write occurs; data_out = 0.
- en = 1 during BUSY: ignored; err pulses in the following cycle; the in-flight request is unaffected.
- Simultaneous events: done and a new accept in the same cycle are legal; err from a BUSY-time en and err from an unaligned completion OR together.
- Read-after-write to the same word, back-to-back: the read returns the new data, because the commit precedes the read's DONE edge.

Optional Feature:
- Macro: MEM_RESPONDER_LASTHIT_EN.
- Defined: keep last_idx and last_vld, both cleared at reset.
  - Any completed access (read or write, aligned) sets last_idx to its index and last_vld = 1.
  - An aligned read accepted with last_vld & index == last_idx goes straight to DONE: latency 1, hit = 1 with done, stall low in the following cycle.
  - Writes and misses use the full LATENCY.
- Undefined: hit tied 0; every request takes LATENCY cycles.

Decomposition:
- Package mem_responder_pkg:
  - state enum {IDLE, BUSY, DONE};
  - LATENCY_MIN = 1, LATENCY_MAX = 15, count width = 4;
  - DATA_W = 16.
- Sub-module mem_responder_array: DEPTH x 16 storage with one synchronous write port, one combinational read port, and async active-low clear.
- FSM, counter, and error logic stay in the top level.

Test Plan:
- Reset, then write addr 0x0010 data 0xBEEF, LATENCY = 4, accept at T:
  - stall high T..T+3; done at T+4 only; err = 0.
- Read addr 0x0010 at the next idle:
  - data_out = 0xBEEF exactly at done (T+4), held after; hit = 0 unless the macro is defined, in which case hit = 1 and done follows at T+1.
- Back-to-back: write 0x0020 = 0x1234 with a read of 0x0020 presented in the done cycle:
  - second done 4 cycles later with data_out = 0x1234; no idle bubble.
- Unaligned read addr 0x0011:
  - done at T+4 with err = 1 and data_out = 0x0000.
  - Repeat as a write of 0x5555 to 0x0011, then read 0x0010: the array is unchanged (returns 0xBEEF).
- en pulsed during BUSY:
  - err one cycle later; the original request completes normally at T+4.
- Reset mid-operation: rst = 0 two cycles after accepting write 0x0030 = 0xAAAA:
  - all outputs 0 immediately; a later read of 0x0030 returns 0x0000.
- Wrap: with DEPTH = 256, write 0x0200 = 0x7777:
  - a read of 0x0000 returns 0x7777.
